// File: rtl/tristate_serializer.sv
// tristate_serializer: parallel-to-serial front end for a tristate output stage.
// Words arrive over valid/ready and leave MSB-first on ser_out, with oe_out framing
// the driven bits and a programmable turnaround gap between words.
// Optional macro TRISTATE_SER_OE_ALIGN_EN delays oe_out by two flops to line up
// with a downstream stage that registers data twice but uses oe directly.
module tristate_serializer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned TURNAROUND = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_out,
    output logic             oe_out,
    output logic             tx_done,
    output logic             busy
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] BitInit = CntW'(WIDTH - 1);
    // Unused when TURNAROUND is 0; keep the subtraction from underflowing.
    localparam logic [3:0] TurnInit = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StTurn
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] shift_reg;
    logic [CntW-1:0] bit_cnt;
    logic [3:0]      turn_cnt;
    logic            oe_q;
    logic            tx_done_q;

    // Control FSM: capture, shift out, then hold the bus idle for the turnaround.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            shift_reg <= '0;
            bit_cnt   <= '0;
            turn_cnt  <= '0;
            oe_q      <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (state)
                StIdle: begin
                    if (data_valid) begin
                        shift_reg <= data_in;
                        bit_cnt   <= BitInit;
                        oe_q      <= 1'b1;
                        state     <= StShift;
                    end
                end
                StShift: begin
                    if (bit_cnt != '0) begin
                        shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                        bit_cnt   <= bit_cnt - CntW'(1);
                    end else begin
                        oe_q      <= 1'b0;
                        shift_reg <= '0;
                        tx_done_q <= 1'b1;
                        if (TURNAROUND > 0) begin
                            turn_cnt <= TurnInit;
                            state    <= StTurn;
                        end else begin
                            state <= StIdle;
                        end
                    end
                end
                StTurn: begin
                    if (turn_cnt != 4'd0) begin
                        turn_cnt <= turn_cnt - 4'd1;
                    end else begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign data_ready = (state == StIdle);
    assign busy       = (state != StIdle);
    // Shift register is cleared outside SHIFT, so the MSB is 0 whenever not driving.
    assign ser_out    = shift_reg[WIDTH-1];
    assign tx_done    = tx_done_q;

`ifdef TRISTATE_SER_OE_ALIGN_EN
    logic [1:0] oe_dly;

    // Two-flop delay on the enable to match the downstream data pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oe_dly <= 2'b00;
        end else begin
            oe_dly <= {oe_dly[0], oe_q};
        end
    end

    assign oe_out = oe_dly[1];
`else
    assign oe_out = oe_q;
`endif

endmodule
